// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - phase state and lamp code definitions for the traffic-light sequencer
package tl_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101,
    S6 = 3'b110,
    S7 = 3'b111
  } tl_state_t;

  typedef enum logic [1:0] {
    GRN = 2'b00,
    YEL = 2'b01,
    LFT = 2'b10,
    RED = 2'b11
  } tl_lamp_t;

endpackage

// File: rtl/tl_lamp_decode.sv
// rtl/tl_lamp_decode.sv - combinational map from phase state to road A/B lamp codes
module tl_lamp_decode
  import tl_pkg::*;
(
  input  logic [2:0] q,
  output logic [1:0] la,
  output logic [1:0] lb
);

  always_comb begin
    la = GRN;
    lb = RED;
    case (tl_state_t'(q))
      S0: begin la = GRN; lb = RED; end
      S1: begin la = YEL; lb = RED; end
      S2: begin la = LFT; lb = RED; end
      S3: begin la = YEL; lb = RED; end
      S4: begin la = RED; lb = GRN; end
      S5: begin la = RED; lb = YEL; end
      S6: begin la = RED; lb = LFT; end
      S7: begin la = RED; lb = YEL; end
    endcase
  end

endmodule

// File: rtl/tl_phase_ctrl.sv
// rtl/tl_phase_ctrl.sv - two-road phase sequencer with dwell timer; TL_TIMER_OUT_EN adds tmr_out
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int TW         = 8,
  parameter int MIN_GREEN  = 5,
  parameter int MAX_GREEN  = 20,
  parameter int YELLOW_CYC = 3,
  parameter int LEFT_CYC   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          Ta,
  input  logic          Tb,
  input  logic          left_a,
  input  logic          left_b,
  output logic [2:0]    Q,
  output logic [1:0]    La,
  output logic [1:0]    Lb,
  output logic          phase_done
`ifdef TL_TIMER_OUT_EN
  ,
  output logic [TW-1:0] tmr_out
`endif
);

  localparam logic [TW-1:0] MIN_G_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_G_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST   = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] LEFT_LAST  = TW'(LEFT_CYC - 1);

  tl_state_t     state_q;
  tl_state_t     state_d;
  logic [TW-1:0] timer;
  logic          pend_a;
  logic          pend_b;
  logic          tx;
  logic          exit_g;
  logic          yel_done;
  logic          left_done;

  // Only S0 and S4 consult exit_g, so tx only needs to pick the road in green.
  always_comb begin
    tx        = (state_q == S4) ? Tb : Ta;
    exit_g    = ((timer >= MIN_G_LAST) && !tx) || (timer == MAX_G_LAST);
    yel_done  = (timer == YEL_LAST);
    left_done = (timer == LEFT_LAST);
    state_d   = state_q;
    case (state_q)
      S0: if (exit_g)    state_d = S1;
      S1: if (yel_done)  state_d = pend_a ? S2 : S4;
      S2: if (left_done) state_d = S3;
      S3: if (yel_done)  state_d = S4;
      S4: if (exit_g)    state_d = S5;
      S5: if (yel_done)  state_d = pend_b ? S6 : S0;
      S6: if (left_done) state_d = S7;
      S7: if (yel_done)  state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S0;
      timer      <= '0;
      pend_a     <= 1'b0;
      pend_b     <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_done <= (state_d != state_q);
      timer      <= (state_d != state_q) ? '0 : timer + 1'b1;
      // Entering the left-turn phase serves the request, even one arriving on that edge.
      if (state_d == S2 && state_q != S2)
        pend_a <= 1'b0;
      else if (left_a && state_q != S2)
        pend_a <= 1'b1;
      if (state_d == S6 && state_q != S6)
        pend_b <= 1'b0;
      else if (left_b && state_q != S6)
        pend_b <= 1'b1;
    end
  end

  assign Q = state_q;

`ifdef TL_TIMER_OUT_EN
  assign tmr_out = timer;
`endif

  tl_lamp_decode u_lamp_decode (
    .q  (state_q),
    .la (La),
    .lb (Lb)
  );

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// tb/tb_tl_phase_ctrl.sv - scoreboard bench for tl_phase_ctrl phase sequence and dwell times
module tb_tl_phase_ctrl;

  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          Ta = 1'b0;
  logic          Tb = 1'b0;
  logic          left_a = 1'b0;
  logic          left_b = 1'b0;
  logic [2:0]    Q;
  logic [1:0]    La;
  logic [1:0]    Lb;
  logic          phase_done;
`ifdef TL_TIMER_OUT_EN
  logic [TW-1:0] tmr_out;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0] q;
    logic [1:0] la;
    logic [1:0] lb;
    int         dur;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_cnt = 0;

  tl_phase_ctrl #(
    .TW(TW), .MIN_GREEN(5), .MAX_GREEN(20), .YELLOW_CYC(3), .LEFT_CYC(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Ta         (Ta),
    .Tb         (Tb),
    .left_a     (left_a),
    .left_b     (left_b),
    .Q          (Q),
    .La         (La),
    .Lb         (Lb),
    .phase_done (phase_done)
`ifdef TL_TIMER_OUT_EN
    ,
    .tmr_out    (tmr_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] q, input logic [1:0] la, input logic [1:0] lb,
                      input int dur);
    exp_t e;
    e.q = q; e.la = la; e.lb = lb; e.dur = dur;
    exp_q.push_back(e);
  endtask

  // Each phase_done pulse announces a new phase; the duration of the phase just left is checked too.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_cnt = 0;
    end else if (phase_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_phase: got Q=%0d expected no transition at %0t", Q, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("phase_q", 32'(Q), 32'(mon_e.q));
        chk("phase_la", 32'(La), 32'(mon_e.la));
        chk("phase_lb", 32'(Lb), 32'(mon_e.lb));
        chk("prev_dwell", 32'(mon_cnt), 32'(mon_e.dur));
      end
      mon_cnt = 1;
    end else begin
      mon_cnt++;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_q(input logic [2:0] target, input int budget);
    int i = 0;
    while (Q !== target && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("wait_state", 32'(Q), 32'(target));
  endtask

  task automatic wait_empty(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset, no traffic: minimum greens, plain yellows
    do_reset(2);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_la", 32'(La), 32'd0);
    chk("rst_lb", 32'(Lb), 32'd3);
    chk("rst_done", 32'(phase_done), 32'd0);
    push(3'b001, 2'b01, 2'b11, 5);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 5);
    push(3'b000, 2'b00, 2'b11, 3);
`ifdef TL_TIMER_OUT_EN
    wait_q(3'b001, 50);
    chk("tmr_s1_0", 32'(tmr_out), 32'd0);
    @(posedge clk); #1;
    chk("tmr_s1_1", 32'(tmr_out), 32'd1);
    @(posedge clk); #1;
    chk("tmr_s1_2", 32'(tmr_out), 32'd2);
    @(posedge clk); #1;
    chk("tmr_s4_0", 32'(tmr_out), 32'd0);
    chk("tmr_s4_q", 32'(Q), 32'd4);
`endif
    wait_empty(100);

    // Traffic held on both roads: max-green timeouts
    Ta = 1'b1;
    Tb = 1'b1;
    do_reset(2);
    push(3'b001, 2'b01, 2'b11, 20);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 20);
    push(3'b000, 2'b00, 2'b11, 3);
    wait_empty(200);
    Ta = 1'b0;
    Tb = 1'b0;

    // Left-turn service on road A
    do_reset(2);
    push(3'b001, 2'b01, 2'b11, 5);
    push(3'b010, 2'b10, 2'b11, 3);
    push(3'b011, 2'b01, 2'b11, 4);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 5);
    push(3'b000, 2'b00, 2'b11, 3);
    @(posedge clk); #1;
    left_a = 1'b1;
    @(posedge clk); #1;
    left_a = 1'b0;
    chk("pend_a_set", 32'(dut.pend_a), 32'd1);
    wait_q(3'b010, 50);
    chk("pend_a_served", 32'(dut.pend_a), 32'd0);
    wait_empty(200);

    // left_b held through the edge entering S6: clear wins, next S5 skips S6
    do_reset(2);
    push(3'b001, 2'b01, 2'b11, 5);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 5);
    push(3'b110, 2'b11, 2'b10, 3);
    push(3'b111, 2'b11, 2'b01, 4);
    push(3'b000, 2'b00, 2'b11, 3);
    push(3'b001, 2'b01, 2'b11, 5);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 5);
    push(3'b000, 2'b00, 2'b11, 3);
    wait_q(3'b100, 50);
    left_b = 1'b1;
    wait_q(3'b110, 50);
    left_b = 1'b0;
    chk("pend_b_collide", 32'(dut.pend_b), 32'd0);
    wait_empty(200);

    // Reset in S6 with timer=2 and a pending request
    do_reset(2);
    @(posedge clk); #1;
    left_b = 1'b1;
    @(posedge clk); #1;
    left_b = 1'b0;
    push(3'b001, 2'b01, 2'b11, 5);
    push(3'b100, 2'b11, 2'b00, 3);
    push(3'b101, 2'b11, 2'b01, 5);
    push(3'b110, 2'b11, 2'b10, 3);
    wait_q(3'b110, 50);
    left_a = 1'b1;
    @(posedge clk); #1;
    left_a = 1'b0;
    @(posedge clk); #1;
    chk("mid_timer", 32'(dut.timer), 32'd2);
    chk("mid_pend_a", 32'(dut.pend_a), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_q", 32'(Q), 32'd0);
    chk("mid_rst_timer", 32'(dut.timer), 32'd0);
    chk("mid_rst_pend_a", 32'(dut.pend_a), 32'd0);
    chk("mid_rst_pend_b", 32'(dut.pend_b), 32'd0);
    chk("mid_rst_la", 32'(La), 32'd0);
    chk("mid_rst_lb", 32'(Lb), 32'd3);
    chk("mid_rst_done", 32'(phase_done), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
